// File: rtl/usb_rx_field_sequencer_pkg.sv
// Shared types and constants for the USB receive field sequencer.
// State encoding is one-hot so the phase strobes are taken directly from state bits.
package usb_pkg;

  typedef enum logic [8:0] {
    ST_IDLE  = 9'b0_0000_0001,
    ST_PID   = 9'b0_0000_0010,
    ST_ADDR  = 9'b0_0000_0100,
    ST_ENDP  = 9'b0_0000_1000,
    ST_CRC5  = 9'b0_0001_0000,
    ST_FRAME = 9'b0_0010_0000,
    ST_DATA  = 9'b0_0100_0000,
    ST_EOP   = 9'b0_1000_0000,
    ST_ERROR = 9'b1_0000_0000
  } state_t;

  localparam int unsigned PID_W   = 8;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned ENDP_W  = 4;
  localparam int unsigned CRC5_W  = 5;
  localparam int unsigned FRAME_W = 11;

  // Arrival order, oldest bit in the MSB.
  localparam logic [7:0] SYNC_PATTERN = 8'b0000_0001;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_PING  = 4'b0100;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_DATA2 = 4'b0111;
  localparam logic [3:0] PID_MDATA = 4'b1111;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_NYET  = 4'b0110;

  function automatic state_t pid_next_state(input logic [3:0] p);
    case (p)
      PID_OUT, PID_IN, PID_SETUP, PID_PING:       return ST_ADDR;
      PID_SOF:                                    return ST_FRAME;
      PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA: return ST_DATA;
      PID_ACK, PID_NAK, PID_STALL, PID_NYET:      return ST_EOP;
      default:                                    return ST_ERROR;
    endcase
  endfunction

endpackage

// File: rtl/usb_rx_field_sequencer_if.sv
// Decoded-bit bus from the NRZI decoder into the receive field sequencer.
interface usb_rx_field_sequencer_if;
  logic rx_bit;
  logic rx_bit_valid;
  logic se0;

  modport master (output rx_bit, output rx_bit_valid, output se0);
  modport slave  (input  rx_bit, input  rx_bit_valid, input  se0);
endinterface

// File: rtl/usb_rx_field_sequencer_unstuffer.sv
// Removes the stuffed 0 after six consecutive 1s and flags a seventh 1.
// While disabled it only remembers the last bit, so the SYNC-ending 1 seeds a run of one.
module usb_bit_unstuffer (
  input  logic gclk,
  input  logic reset_l,
  input  logic rx_bit,
  input  logic rx_bit_valid,
  input  logic enable,
  output logic bit_out,
  output logic bit_out_valid,
  output logic stuff_err_pulse
);
  localparam logic [2:0] MAX_RUN = 3'd6;

  logic [2:0] ones_cnt, ones_nxt;

  always_comb begin
    bit_out         = rx_bit;
    bit_out_valid   = 1'b0;
    stuff_err_pulse = 1'b0;
    ones_nxt        = ones_cnt;
    if (rx_bit_valid) begin
      if (!enable) begin
        bit_out_valid = 1'b1;
        ones_nxt      = {2'b00, rx_bit};
      end else if (ones_cnt == MAX_RUN) begin
        stuff_err_pulse = rx_bit;
        ones_nxt        = '0;
      end else begin
        bit_out_valid = 1'b1;
        ones_nxt      = rx_bit ? ones_cnt + 3'd1 : '0;
      end
    end
  end

  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) ones_cnt <= '0;
    else          ones_cnt <= ones_nxt;
  end

endmodule

// File: rtl/usb_rx_field_sequencer.sv
// USB 2.0 receive field sequencer: SYNC detect, PID decode, field capture and
// one-hot phase strobes, with bit unstuffing between SYNC and EOP.
module usb_rx_field_sequencer
  import usb_pkg::*;
#(
  parameter int unsigned EOP_BITS      = 2,
  parameter int unsigned MAX_DATA_BITS = 8208
) (
  input  logic                   gclk,
  input  logic                   reset_l,
  input  logic                   start_rxd,
  usb_rx_field_sequencer_if.slave rx,
  output logic                   idle_or_sync,
  output logic                   pid,
  output logic                   dev_address,
  output logic                   end_point_address,
  output logic                   crc5,
  output logic                   frame_number,
  output logic                   data_crc_eop,
  output logic                   eop,
  output logic                   error,
  output logic [3:0]             pid_value,
  output logic [ADDR_W-1:0]      addr,
  output logic [ENDP_W-1:0]      endp,
  output logic [FRAME_W-1:0]     frame_num,
  output logic                   packet_done,
  output logic                   pid_err,
  output logic                   stuff_err
);
  localparam int unsigned DCW = $clog2(MAX_DATA_BITS + 2);
  localparam int unsigned SCW = $clog2(EOP_BITS + 1);
  localparam logic [DCW-1:0] DATA_LIMIT = DCW'(MAX_DATA_BITS + 1);
  localparam logic [DCW-1:0] DATA_MIN   = DCW'(16);
  localparam logic [SCW-1:0] EOP_LEN    = SCW'(EOP_BITS);

  state_t               state, state_nxt;
  logic [6:0]           sync_sh, sync_sh_nxt;
  logic [FRAME_W-2:0]   fld_sh, fld_sh_nxt;
  logic [3:0]           bit_cnt, bit_cnt_nxt;
  logic [DCW-1:0]       data_cnt, data_cnt_nxt;
  logic [SCW-1:0]       se0_cnt, se0_cnt_nxt;
  logic [3:0]           pid_value_nxt;
  logic [ADDR_W-1:0]    addr_nxt;
  logic [ENDP_W-1:0]    endp_nxt;
  logic [FRAME_W-1:0]   frame_num_nxt;
  logic                 packet_done_nxt, pid_err_nxt, stuff_err_nxt;

  logic                 us_enable, us_in_valid, us_bit, us_valid, us_stuff_err;
  logic [7:0]           sync_in;
  logic [FRAME_W-1:0]   fld_in;
  logic [PID_W-1:0]     pid_byte;
  logic [SCW-1:0]       se0_inc;
  logic                 eop_seen;

  assign us_enable   = !(state inside {ST_IDLE, ST_ERROR});
  assign us_in_valid = rx.rx_bit_valid && !rx.se0;

  usb_bit_unstuffer u_unstuffer (
    .gclk            (gclk),
    .reset_l         (reset_l),
    .rx_bit          (rx.rx_bit),
    .rx_bit_valid    (us_in_valid),
    .enable          (us_enable),
    .bit_out         (us_bit),
    .bit_out_valid   (us_valid),
    .stuff_err_pulse (us_stuff_err)
  );

  // Fields arrive LSB first, so they are shifted in from the top; a field of
  // width W ends up in the W most significant bits of fld_in.
  assign sync_in  = {sync_sh, rx.rx_bit};
  assign fld_in   = {us_bit, fld_sh};
  assign pid_byte = fld_in[FRAME_W-1 -: PID_W];
  assign se0_inc  = (se0_cnt == EOP_LEN) ? se0_cnt : se0_cnt + SCW'(1);
  assign eop_seen = (se0_inc == EOP_LEN);

  always_comb begin
    state_nxt       = state;
    sync_sh_nxt     = sync_sh;
    fld_sh_nxt      = fld_sh;
    bit_cnt_nxt     = bit_cnt;
    data_cnt_nxt    = data_cnt;
    se0_cnt_nxt     = se0_cnt;
    pid_value_nxt   = pid_value;
    addr_nxt        = addr;
    endp_nxt        = endp;
    frame_num_nxt   = frame_num;
    packet_done_nxt = 1'b0;
    pid_err_nxt     = pid_err;
    stuff_err_nxt   = stuff_err;

    if (!start_rxd) begin
      state_nxt   = ST_IDLE;
      sync_sh_nxt = '0;
    end else if (rx.rx_bit_valid) begin
      if (us_stuff_err) begin
        stuff_err_nxt = 1'b1;
        state_nxt     = ST_ERROR;
      end else begin
        unique case (state)
          ST_IDLE: begin
            sync_sh_nxt = sync_in[6:0];
            if (sync_in == SYNC_PATTERN) begin
              pid_err_nxt   = 1'b0;
              stuff_err_nxt = 1'b0;
              state_nxt     = ST_PID;
            end
          end
          ST_PID, ST_ADDR, ST_ENDP, ST_CRC5, ST_FRAME: begin
            if (rx.se0) begin
              state_nxt = ST_ERROR;
            end else if (us_valid) begin
              fld_sh_nxt  = fld_in[FRAME_W-1:1];
              bit_cnt_nxt = bit_cnt + 4'd1;
              if (state == ST_PID && bit_cnt == 4'(PID_W - 1)) begin
                pid_value_nxt = pid_byte[3:0];
                if (pid_byte[7:4] != ~pid_byte[3:0]) begin
                  pid_err_nxt = 1'b1;
                  state_nxt   = ST_ERROR;
                end else begin
                  state_nxt = pid_next_state(pid_byte[3:0]);
                end
              end else if (state == ST_ADDR && bit_cnt == 4'(ADDR_W - 1)) begin
                addr_nxt  = fld_in[FRAME_W-1 -: ADDR_W];
                state_nxt = ST_ENDP;
              end else if (state == ST_ENDP && bit_cnt == 4'(ENDP_W - 1)) begin
                endp_nxt  = fld_in[FRAME_W-1 -: ENDP_W];
                state_nxt = ST_CRC5;
              end else if (state == ST_FRAME && bit_cnt == 4'(FRAME_W - 1)) begin
                frame_num_nxt = fld_in;
                state_nxt     = ST_CRC5;
              end else if (state == ST_CRC5 && bit_cnt == 4'(CRC5_W - 1)) begin
                state_nxt = ST_EOP;
              end
            end
          end
          ST_DATA: begin
            if (rx.se0) begin
              se0_cnt_nxt = se0_inc;
              if (eop_seen) begin
                if (data_cnt >= DATA_MIN && data_cnt[2:0] == 3'd0) begin
                  packet_done_nxt = 1'b1;
                  state_nxt       = ST_IDLE;
                end else begin
                  state_nxt = ST_ERROR;
                end
              end
            end else begin
              se0_cnt_nxt = '0;
              if (us_valid && data_cnt != DATA_LIMIT) begin
                data_cnt_nxt = data_cnt + DCW'(1);
                if (data_cnt_nxt == DATA_LIMIT) state_nxt = ST_ERROR;
              end
            end
          end
          ST_EOP: begin
            if (rx.se0) begin
              se0_cnt_nxt = se0_inc;
              if (eop_seen) begin
                packet_done_nxt = 1'b1;
                state_nxt       = ST_IDLE;
              end
            end else if (us_valid) begin
              state_nxt = ST_ERROR;
            end
          end
          ST_ERROR: begin
            if (rx.se0) begin
              se0_cnt_nxt = se0_inc;
              if (eop_seen) state_nxt = ST_IDLE;
            end else begin
              se0_cnt_nxt = '0;
            end
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end

    // Every phase starts its bit, data and SE0 counts from zero.
    if (state_nxt != state) begin
      bit_cnt_nxt  = '0;
      data_cnt_nxt = '0;
      se0_cnt_nxt  = '0;
    end
  end

  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      state       <= ST_IDLE;
      sync_sh     <= '0;
      fld_sh      <= '0;
      bit_cnt     <= '0;
      data_cnt    <= '0;
      se0_cnt     <= '0;
      pid_value   <= '0;
      addr        <= '0;
      endp        <= '0;
      frame_num   <= '0;
      packet_done <= 1'b0;
      pid_err     <= 1'b0;
      stuff_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      sync_sh     <= sync_sh_nxt;
      fld_sh      <= fld_sh_nxt;
      bit_cnt     <= bit_cnt_nxt;
      data_cnt    <= data_cnt_nxt;
      se0_cnt     <= se0_cnt_nxt;
      pid_value   <= pid_value_nxt;
      addr        <= addr_nxt;
      endp        <= endp_nxt;
      frame_num   <= frame_num_nxt;
      packet_done <= packet_done_nxt;
      pid_err     <= pid_err_nxt;
      stuff_err   <= stuff_err_nxt;
    end
  end

  assign {error, eop, data_crc_eop, frame_number, crc5,
          end_point_address, dev_address, pid, idle_or_sync} = state;

endmodule

// File: tb/tb_usb_rx_field_sequencer.sv
// Directed bench for usb_rx_field_sequencer: token, SOF, data, handshake and error packets.
module tb_usb_rx_field_sequencer;

  localparam logic [8:0] S_IDLE  = 9'h001;
  localparam logic [8:0] S_PID   = 9'h002;
  localparam logic [8:0] S_ADDR  = 9'h004;
  localparam logic [8:0] S_ENDP  = 9'h008;
  localparam logic [8:0] S_CRC5  = 9'h010;
  localparam logic [8:0] S_FRAME = 9'h020;
  localparam logic [8:0] S_DATA  = 9'h040;
  localparam logic [8:0] S_EOP   = 9'h080;
  localparam logic [8:0] S_ERROR = 9'h100;

  logic gclk = 1'b0;
  logic reset_l;
  logic start_rxd;
  usb_rx_field_sequencer_if rxif ();

  logic idle_or_sync, pid, dev_address, end_point_address, crc5;
  logic frame_number, data_crc_eop, eop, error;
  logic [3:0]  pid_value;
  logic [6:0]  addr;
  logic [3:0]  endp;
  logic [10:0] frame_num;
  logic packet_done, pid_err, stuff_err;
  logic [8:0] stb;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned done_cnt = 0;
  int unsigned onehot_viol = 0;

  usb_rx_field_sequencer #(.EOP_BITS(2), .MAX_DATA_BITS(8208)) dut (
    .gclk              (gclk),
    .reset_l           (reset_l),
    .start_rxd         (start_rxd),
    .rx                (rxif),
    .idle_or_sync      (idle_or_sync),
    .pid               (pid),
    .dev_address       (dev_address),
    .end_point_address (end_point_address),
    .crc5              (crc5),
    .frame_number      (frame_number),
    .data_crc_eop      (data_crc_eop),
    .eop               (eop),
    .error             (error),
    .pid_value         (pid_value),
    .addr              (addr),
    .endp              (endp),
    .frame_num         (frame_num),
    .packet_done       (packet_done),
    .pid_err           (pid_err),
    .stuff_err         (stuff_err)
  );

  assign stb = {error, eop, data_crc_eop, frame_number, crc5,
                end_point_address, dev_address, pid, idle_or_sync};

  always #5 gclk = ~gclk;

  always @(negedge gclk) begin
    if (packet_done === 1'b1) done_cnt++;
    if (!$onehot(stb)) onehot_viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic s);
    @(negedge gclk);
    rxif.rx_bit       = b;
    rxif.se0          = s;
    rxif.rx_bit_valid = 1'b1;
    @(posedge gclk);
    #1;
    rxif.rx_bit_valid = 1'b0;
    rxif.se0          = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i], 1'b0);
  endtask

  task automatic send_se0(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, 1'b1);
  endtask

  task automatic send_sync();
    send_bits(32'h80, 8);
  endtask

  initial begin
    reset_l           = 1'b0;
    start_rxd         = 1'b1;
    rxif.rx_bit       = 1'b0;
    rxif.rx_bit_valid = 1'b0;
    rxif.se0          = 1'b0;
    repeat (2) @(posedge gclk);
    #1;
    check("rst_strobes", 32'(stb), 32'(S_IDLE));
    check("rst_fields", {pid_value, addr, endp, frame_num}, 32'h0);
    check("rst_flags", {packet_done, pid_err, stuff_err}, 32'h0);
    @(negedge gclk) reset_l = 1'b1;

    // IN token: addr 5, endp 3
    send_sync();
    check("in_sync", 32'(stb), 32'(S_PID));
    send_bits(32'h69, 8);
    check("in_pid_strobe", 32'(stb), 32'(S_ADDR));
    check("in_pid_value", 32'(pid_value), 32'h9);
    send_bits(32'h05, 7);
    check("in_addr_strobe", 32'(stb), 32'(S_ENDP));
    send_bits(32'h3, 4);
    check("in_endp_strobe", 32'(stb), 32'(S_CRC5));
    send_bits(32'b01010, 5);
    check("in_crc_strobe", 32'(stb), 32'(S_EOP));
    send_se0(1);
    check("in_eop_half", 32'(stb), 32'(S_EOP));
    send_se0(1);
    check("in_idle", 32'(stb), 32'(S_IDLE));
    check("in_done", 32'(packet_done), 32'h1);
    check("in_addr", 32'(addr), 32'h05);
    check("in_endp", 32'(endp), 32'h3);

    // SOF, frame 0x7FF: stuffed 0 after five frame 1s (run began on PID's last 1)
    send_sync();
    send_bits(32'hA5, 8);
    check("sof_pid_strobe", 32'(stb), 32'(S_FRAME));
    send_bits(32'h1F, 5);
    send_bit(1'b0, 1'b0);
    check("sof_stuffed_held", 32'(stb), 32'(S_FRAME));
    send_bits(32'h3F, 6);
    check("sof_frame_done", 32'(stb), 32'(S_CRC5));
    check("sof_frame_num", 32'(frame_num), 32'h7FF);
    send_bit(1'b0, 1'b0);
    check("sof_crc_stuffed_held", 32'(stb), 32'(S_CRC5));
    send_bits(32'h0, 5);
    check("sof_crc_strobe", 32'(stb), 32'(S_EOP));
    send_se0(2);
    check("sof_idle", 32'(stb), 32'(S_IDLE));
    check("sof_done", 32'(packet_done), 32'h1);
    check("sof_no_stuff_err", 32'(stuff_err), 32'h0);

    // DATA0 with 24 bits
    send_sync();
    send_bits(32'hC3, 8);
    check("d0_strobe", 32'(stb), 32'(S_DATA));
    check("d0_pid_value", 32'(pid_value), 32'h3);
    send_bits(32'h563412, 24);
    send_se0(1);
    check("d0_eop_half", 32'(stb), 32'(S_DATA));
    send_se0(1);
    check("d0_idle", 32'(stb), 32'(S_IDLE));
    check("d0_done", 32'(packet_done), 32'h1);

    // DATA1 with 21 bits: not byte aligned
    send_sync();
    send_bits(32'h4B, 8);
    check("d1_strobe", 32'(stb), 32'(S_DATA));
    send_bits(32'h0, 21);
    send_se0(2);
    check("d1_error", 32'(stb), 32'(S_ERROR));
    check("d1_no_done", 32'(packet_done), 32'h0);
    send_se0(1);
    check("d1_err_hold", 32'(stb), 32'(S_ERROR));
    send_se0(1);
    check("d1_idle", 32'(stb), 32'(S_IDLE));

    // ACK with bad check nibble, then a good ACK
    send_sync();
    send_bits(32'hF2, 8);
    check("ack_bad_error", 32'(stb), 32'(S_ERROR));
    check("ack_bad_pid_err", 32'(pid_err), 32'h1);
    check("ack_bad_pid_value", 32'(pid_value), 32'h2);
    send_se0(2);
    check("ack_bad_idle", 32'(stb), 32'(S_IDLE));
    check("ack_pid_err_sticky", 32'(pid_err), 32'h1);
    send_sync();
    check("ack_sync_clears", 32'(pid_err), 32'h0);
    send_bits(32'hD2, 8);
    check("ack_good_eop", 32'(stb), 32'(S_EOP));
    send_se0(2);
    check("ack_good_idle", 32'(stb), 32'(S_IDLE));
    check("ack_good_done", 32'(packet_done), 32'h1);

    // Seven 1s inside the address field
    send_sync();
    send_bits(32'h69, 8);
    send_bits(32'h3F, 6);
    check("stuff_addr_pre", 32'(stb), 32'(S_ADDR));
    send_bit(1'b1, 1'b0);
    check("stuff_error", 32'(stb), 32'(S_ERROR));
    check("stuff_err_flag", 32'(stuff_err), 32'h1);
    check("stuff_addr_held", 32'(addr), 32'h05);
    send_se0(2);
    check("stuff_idle", 32'(stb), 32'(S_IDLE));

    // start_rxd low mid-address
    send_sync();
    check("rxd_sync_clears", 32'(stuff_err), 32'h0);
    send_bits(32'h69, 8);
    send_bits(32'b011, 3);
    check("rxd_in_addr", 32'(stb), 32'(S_ADDR));
    @(negedge gclk) start_rxd = 1'b0;
    @(posedge gclk);
    #1;
    check("rxd_idle", 32'(stb), 32'(S_IDLE));
    check("rxd_addr_held", 32'(addr), 32'h05);
    @(negedge gclk) start_rxd = 1'b1;

    // Data overflow boundary
    send_sync();
    send_bits(32'hC3, 8);
    for (int i = 0; i < 8208; i++) send_bit(1'b0, 1'b0);
    check("ovf_at_max", 32'(stb), 32'(S_DATA));
    send_bit(1'b0, 1'b0);
    check("ovf_error", 32'(stb), 32'(S_ERROR));
    send_se0(2);
    check("ovf_idle", 32'(stb), 32'(S_IDLE));

    // Asynchronous reset mid-data
    send_sync();
    send_bits(32'hC3, 8);
    send_bits(32'h0, 10);
    check("rst_mid_data", 32'(stb), 32'(S_DATA));
    #2 reset_l = 1'b0;
    #1;
    check("rst_async_strobes", 32'(stb), 32'(S_IDLE));
    check("rst_async_fields", {pid_value, addr, endp, frame_num}, 32'h0);
    check("rst_async_flags", {packet_done, pid_err, stuff_err}, 32'h0);
    @(negedge gclk) reset_l = 1'b1;
    repeat (2) @(posedge gclk);
    #1;

    check("packet_done_total", done_cnt, 32'd4);
    check("strobes_onehot", onehot_viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
